// File: rtl/win_pkg.sv
// Shared FSM state type and default frame geometry for the window frame sequencer.
package win_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } win_state_e;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int COL_W_DEF = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF = $clog2(IMG_H_DEF);

endpackage

// File: rtl/win_delay_line.sv
// DEPTH-stage register chain for {flag, row, col}; latency DEPTH clocks, shifts every clock.
// No backpressure; flush zeroes every stage (including the incoming word) on the next edge.
module win_delay_line #(
  parameter int DEPTH = 6,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stage_q;
  logic [DEPTH-1:0][W-1:0] stage_d;

  always_comb begin
    stage_d = '0;
    if (!flush) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/win_frame_ctrl.sv
// Frame sequencer for the 3x3 median datapath; buf_* lag the input 1 clock, win_* lag buf_valid PIPE_LAT clocks.
// No backpressure. Define WIN_LINE_CHK_EN to add the sticky line_err output and window masking.
module win_frame_ctrl
  import win_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int PIPE_LAT = 6,
  parameter int COL_W    = $clog2(IMG_W),
  parameter int ROW_W    = $clog2(IMG_H)
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             vsync,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic [7:0]       buf_din,
  output logic             buf_valid,
  output logic             buf_vsync,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done,
`ifdef WIN_LINE_CHK_EN
  output logic             line_err,
`endif
  output logic             busy
);

  localparam int DL_W  = 1 + ROW_W + COL_W;
  localparam int DRN_W = $clog2(PIPE_LAT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(PIPE_LAT - 1);

  win_state_e       state_q, state_d;
  logic             vs_d_q, vs_d_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [7:0]       buf_din_q, buf_din_d;
  logic             buf_valid_q, buf_valid_d;
  logic             buf_vsync_q, buf_vsync_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic [DL_W-1:0]  win_in_q, win_in_d;
  logic [DL_W-1:0]  win_out;
  logic             vs_rise, flush, restart, interior;
`ifdef WIN_LINE_CHK_EN
  logic             line_err_q, line_err_d;
`endif

  always_comb begin
    vs_d_d       = vsync;
    vs_rise      = vsync & ~vs_d_q;
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    drn_d        = drn_q;
    buf_din_d    = buf_din_q;
    buf_valid_d  = 1'b0;
    buf_vsync_d  = 1'b0;
    frame_done_d = 1'b0;
    win_in_d     = '0;
    flush        = 1'b0;
    restart      = 1'b0;
    interior     = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    case (state_q)
      IDLE: begin
        if (vs_rise) restart = 1'b1;
      end
      ACTIVE: begin
        if (vs_rise) begin
          restart = 1'b1;
          flush   = 1'b1;
        end else if (pix_valid) begin
          buf_valid_d = 1'b1;
          buf_din_d   = pix_data;
          // Centre of the 3x3 window completed by this pixel.
          if (interior) win_in_d = {1'b1, row_q - ROW_W'(1), col_q - COL_W'(1)};
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              drn_d   = DRN_INIT;
              state_d = DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (vs_rise) begin
          restart = 1'b1;
          flush   = 1'b1;
        end else if (drn_q == '0) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      DONE: begin
        // The last window leaves the pipe this cycle, so frame_done follows it.
        frame_done_d = 1'b1;
        state_d      = IDLE;
        if (vs_rise) restart = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (restart) begin
      state_d     = ACTIVE;
      col_d       = '0;
      row_d       = '0;
      buf_vsync_d = 1'b1;
    end
    busy_d = (state_d != IDLE);

`ifdef WIN_LINE_CHK_EN
    line_err_d = line_err_q;
    if (flush) begin
      line_err_d = 1'b1;
    end else if (restart) begin
      line_err_d = 1'b0;
    end else if (state_q == ACTIVE && !pix_valid && col_q != '0) begin
      line_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      vs_d_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      drn_q        <= '0;
      buf_din_q    <= '0;
      buf_valid_q  <= 1'b0;
      buf_vsync_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      win_in_q     <= '0;
`ifdef WIN_LINE_CHK_EN
      line_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vs_d_q       <= vs_d_d;
      col_q        <= col_d;
      row_q        <= row_d;
      drn_q        <= drn_d;
      buf_din_q    <= buf_din_d;
      buf_valid_q  <= buf_valid_d;
      buf_vsync_q  <= buf_vsync_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      win_in_q     <= win_in_d;
`ifdef WIN_LINE_CHK_EN
      line_err_q   <= line_err_d;
`endif
    end
  end

  win_delay_line #(
    .DEPTH (PIPE_LAT),
    .W     (DL_W)
  ) u_delay (
    .clk   (sclk),
    .rst   (s_rst),
    .flush (flush),
    .din   (win_in_q),
    .dout  (win_out)
  );

  assign buf_din    = buf_din_q;
  assign buf_valid  = buf_valid_q;
  assign buf_vsync  = buf_vsync_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

`ifdef WIN_LINE_CHK_EN
  assign line_err  = line_err_q;
  assign win_valid = win_out[DL_W-1] & ~line_err_q;
  assign win_row   = line_err_q ? '0 : win_out[COL_W +: ROW_W];
  assign win_col   = line_err_q ? '0 : win_out[0 +: COL_W];
`else
  assign win_valid = win_out[DL_W-1];
  assign win_row   = win_out[COL_W +: ROW_W];
  assign win_col   = win_out[0 +: COL_W];
`endif

endmodule

// File: doc/win_frame_ctrl.md
Name: win_frame_ctrl

Overview:
- Frame-level sequencer in front of the 3x3 median window and line-buffer datapath.
- Accepts a raster pixel stream and drives the line-buffer write strobe and per-frame buffer clear.
- Tracks row/column position and produces a window-valid qualifier, centre coordinates and an end-of-frame pulse, aligned to the filter pipeline output.

Parameters:
- IMG_W, 640, active pixels per line (>=3)
- IMG_H, 480, active lines per frame (>=3)
- PIPE_LAT, 6, clocks from buf_valid of pixel (r,c) to the filter output for window centre (r-1,c-1)
- COL_W, 10, column counter width (clog2(IMG_W))
- ROW_W, 9, row counter width (clog2(IMG_H))

Ports:
- sclk  in  1  clock
- s_rst  in  1  reset, synchronous, active-high
- vsync  in  1  frame start; rising edge starts a frame
- pix_valid  in  1  input pixel qualifier
- pix_data  in  8  input pixel
- buf_din  out  8  pixel to line buffer
- buf_valid  out  1  line-buffer write strobe
- buf_vsync  out  1  one-cycle line-buffer clear pulse
- win_valid  out  1  filter output corresponds to an interior window
- win_row  out  ROW_W  centre row of the current output window
- win_col  out  COL_W  centre column of the current output window
- frame_done  out  1  one-cycle pulse after the last window of a frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, sclk. Reset is synchronous and active-high (s_rst); all state updates on the rising edge of sclk.
- Reset values: all outputs 0, FSM in IDLE, counters 0, delay line cleared.
- vsync rising edge is detected with a registered copy of vsync (vs_d).
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
  - IDLE -> ACTIVE on a vsync rise. Same cycle: buf_vsync=1, col=0, row=0.
  - ACTIVE: each pix_valid cycle writes one pixel.
    - buf_valid=pix_valid, buf_din=pix_data, registered with 1-cycle latency.
    - col increments. At col==IMG_W-1, col wraps to 0 and row increments.
    - When the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DRAIN.
  - DRAIN: runs PIPE_LAT clocks on a down-counter, then goes to DONE. pix_valid is ignored; buf_valid=0.
  - DONE: frame_done=1 for one cycle, then IDLE.
- pix_valid outside ACTIVE is dropped and does not advance the counters.
- Interior flag for an accepted pixel: row>=2 && col>=2. Its centre is (row-1, col-1).
- The flag and centre coordinates pass through a PIPE_LAT-stage shift register clocked every sclk, since the datapath shifts every clock.
  - win_valid, win_row and win_col are the stage-PIPE_LAT outputs.
  - When the flag is 0, win_row and win_col are 0.
- Interior centres per frame: (IMG_H-2)*(IMG_W-2). Exactly that many win_valid cycles occur between a vsync rise and frame_done.
- Window coherence requires continuous pix_valid within a line. Gaps between lines are allowed.
- vsync rise during ACTIVE or DRAIN aborts the frame:
  - counters reset and the delay line is flushed (win_valid forced 0);
  - buf_vsync pulses and the FSM stays in ACTIVE;
  - no frame_done is issued for the aborted frame.
- vsync rise during DONE: frame_done is still issued, then the FSM goes directly to ACTIVE with buf_vsync.
- s_rst mid-frame returns everything to reset values on the next edge. No frame_done is issued.

Optional Feature:
- Macro: WIN_LINE_CHK_EN.
- With the macro:
  - Extra output line_err (1 bit, sticky). Set when pix_valid drops in ACTIVE while col!=0.
  - Also set when a vsync rise aborts an ACTIVE or DRAIN frame.
  - Cleared by s_rst or by a clean IDLE->ACTIVE start.
  - When set, win_valid is masked to 0 for the rest of the frame.
- Without the macro: no line_err port; gaps are not checked.

Decomposition:
- Shared package win_pkg:
  - FSM state enum (IDLE, ACTIVE, DRAIN, DONE);
  - IMG_W/IMG_H defaults and derived COL_W/ROW_W.
- One sub-module: win_delay_line, a parameterised PIPE_LAT-deep register chain carrying {flag, row, col}, with a synchronous flush input.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0, busy=0; pix_valid pulses ignored with buf_valid=0.
- IMG_W=8, IMG_H=6, vsync rise then 48 continuous pixels (values 0..47) ->
  - buf_vsync is a single pulse;
  - buf_din reproduces 0..47;
  - 24 win_valid cycles, the first with win_row=1 and win_col=1, the last with win_row=4 and win_col=6;
  - frame_done arrives PIPE_LAT+1 clocks after the last pixel.
- Same frame with 3 idle cycles between every line -> still 24 win_valid cycles with identical coordinate sequence.
- vsync rise after 20 pixels, then a full frame -> no frame_done for the aborted frame; exactly 24 win_valid cycles, then one frame_done.
- s_rst asserted during DRAIN -> next cycle busy=0, win_valid=0, and frame_done is never raised.
- With WIN_LINE_CHK_EN: pix_valid gap at col=3 of row 2 -> line_err=1 from the next cycle and win_valid stays 0 until the next clean frame start, which clears it.
